// File: rtl/da_dct_pkg.sv
// rtl/da_dct_pkg.sv - shared constants, state enum and address-fold helper for the DA DCT sequencer
package da_dct_pkg;

  localparam int DATA_W   = 16;
  localparam int ROM_W    = 16;
  localparam int ACC_W    = DATA_W + ROM_W + 1;
  localparam int ROM_FRAC = 14;
  localparam int CNT_W    = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    RND   = 3'd3,
    OUT   = 3'd4
  } state_t;

  // Returns {fold, addr}: a set x0 bit mirrors the slice into the lower ROM half.
  function automatic logic [3:0] fold_addr(input logic b0, input logic b1,
                                           input logic b2, input logic b3);
    return b0 ? {1'b1, ~{b1, b2, b3}} : {1'b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/da_dct_row_sequencer_if.sv
// rtl/da_dct_row_sequencer_if.sv - operand, ROM and result signals of the DA sequencer
interface da_dct_row_sequencer_if;
  import da_dct_pkg::*;

  logic                     start;
  logic signed [DATA_W-1:0] x0;
  logic signed [DATA_W-1:0] x1;
  logic signed [DATA_W-1:0] x2;
  logic signed [DATA_W-1:0] x3;
  logic                     busy;
  logic                     rom_cs;
  logic [2:0]               rom_addr;
  logic signed [ROM_W-1:0]  rom_data;
  logic                     y_valid;
  logic                     y_ready;
  logic signed [ACC_W-1:0]  y;

  modport master (
    input  start, x0, x1, x2, x3, rom_data, y_ready,
    output busy, rom_cs, rom_addr, y_valid, y
  );

  modport slave (
    output start, x0, x1, x2, x3, rom_data, y_ready,
    input  busy, rom_cs, rom_addr, y_valid, y
  );

endinterface

// File: rtl/da_shift_acc.sv
// rtl/da_shift_acc.sv - fold/msb negate and MSB-first shift-accumulate; round/saturate when DA_ROUND_EN is defined
module da_shift_acc
  import da_dct_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    en,
  input  logic                    fold,
  input  logic                    msb,
  input  logic signed [ROM_W-1:0] rom_data,
`ifdef DA_ROUND_EN
  input  logic                    rnd,
`endif
  output logic signed [ACC_W-1:0] y
);

  logic signed [ROM_W-1:0] data_q;
  logic                    neg_q;
  logic                    vld_q;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] addend;

  assign term   = {{(ACC_W-ROM_W){data_q[ROM_W-1]}}, data_q};
  assign addend = neg_q ? -term : term;

  // ROM word is captured with its flags, then folded into acc on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      neg_q  <= 1'b0;
      vld_q  <= 1'b0;
      acc    <= '0;
    end else if (clear) begin
      vld_q  <= 1'b0;
      acc    <= '0;
    end else begin
      vld_q  <= en;
      data_q <= rom_data;
      neg_q  <= fold ^ msb;
      if (vld_q) acc <= (acc <<< 1) + addend;
    end
  end

`ifdef DA_ROUND_EN
  localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1 << (ROM_FRAC - 1));
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  logic signed [ACC_W-1:0]  biased;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] rnd_q;

  assign biased  = acc + HALF;
  assign shifted = biased >>> ROM_FRAC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_q <= '0;
    end else if (rnd) begin
      if (shifted > MAX_V)      rnd_q <= MAX_V[DATA_W-1:0];
      else if (shifted < MIN_V) rnd_q <= MIN_V[DATA_W-1:0];
      else                      rnd_q <= shifted[DATA_W-1:0];
    end
  end

  assign y = {{(ACC_W-DATA_W){rnd_q[DATA_W-1]}}, rnd_q};
`else
  assign y = acc;
`endif

endmodule

// File: rtl/da_dct_row_sequencer.sv
// rtl/da_dct_row_sequencer.sv - bit-serial DA sequencer for one DCT coefficient; DA_ROUND_EN adds a round/saturate stage
module da_dct_row_sequencer
  import da_dct_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  da_dct_row_sequencer_if.master bus
);

  state_t            state;
  logic [DATA_W-1:0] sr0, sr1, sr2, sr3;
  logic [CNT_W-1:0]  bit_cnt;
  logic              fold_q;
  logic              msb_q;
  logic              rom_cs_q;
  logic [2:0]        rom_addr_q;
  logic              busy_q;
  logic              y_valid_q;
  logic              acc_clear;

  assign acc_clear    = (state == IDLE) && bus.start;
  assign bus.busy     = busy_q;
  assign bus.rom_cs   = rom_cs_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.y_valid  = y_valid_q;

  // The MSB slice is addressed straight from the inputs so ISSUE starts on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sr0        <= '0;
      sr1        <= '0;
      sr2        <= '0;
      sr3        <= '0;
      bit_cnt    <= '0;
      fold_q     <= 1'b0;
      msb_q      <= 1'b0;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
      y_valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            {fold_q, rom_addr_q} <= fold_addr(bus.x0[DATA_W-1], bus.x1[DATA_W-1],
                                              bus.x2[DATA_W-1], bus.x3[DATA_W-1]);
            msb_q    <= 1'b1;
            rom_cs_q <= 1'b1;
            busy_q   <= 1'b1;
            sr0      <= {bus.x0[DATA_W-2:0], 1'b0};
            sr1      <= {bus.x1[DATA_W-2:0], 1'b0};
            sr2      <= {bus.x2[DATA_W-2:0], 1'b0};
            sr3      <= {bus.x3[DATA_W-2:0], 1'b0};
            bit_cnt  <= CNT_W'(DATA_W - 1);
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          msb_q <= 1'b0;
          if (bit_cnt == '0) begin
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            fold_q     <= 1'b0;
            state      <= DRAIN;
          end else begin
            {fold_q, rom_addr_q} <= fold_addr(sr0[DATA_W-1], sr1[DATA_W-1],
                                              sr2[DATA_W-1], sr3[DATA_W-1]);
            sr0     <= {sr0[DATA_W-2:0], 1'b0};
            sr1     <= {sr1[DATA_W-2:0], 1'b0};
            sr2     <= {sr2[DATA_W-2:0], 1'b0};
            sr3     <= {sr3[DATA_W-2:0], 1'b0};
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        DRAIN: begin
`ifdef DA_ROUND_EN
          state <= RND;
`else
          state     <= OUT;
          y_valid_q <= 1'b1;
`endif
        end
        RND: begin
          state     <= OUT;
          y_valid_q <= 1'b1;
        end
        OUT: begin
          if (bus.y_ready) begin
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  da_shift_acc u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (acc_clear),
    .en       (rom_cs_q),
    .fold     (fold_q),
    .msb      (msb_q),
    .rom_data (bus.rom_data),
`ifdef DA_ROUND_EN
    .rnd      (state == RND),
`endif
    .y        (bus.y)
  );

endmodule

// File: doc/da_dct_row_sequencer.md
# da_dct_row_sequencer

Bit-serial distributed-arithmetic (DA) sequencer for one DCT output coefficient. It accepts four signed butterfly operands, streams their bit-slices MSB-first as a folded 3-bit address into a DA coefficient ROM, and shift-accumulates the returned partial sums. It delivers one full-precision coefficient per transaction on a valid/ready output. One instance sits in front of each per-coefficient ROM in the DCT datapath.

## Interface
- DATA_W, 16, operand width, two's complement
- ROM_W, 16, ROM word width, signed Q1.14
- ACC_W, DATA_W+ROM_W+1 (33), accumulator and result width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; asynchronous, active-low
- start  in  1  load x0..x3 and begin; honoured only in IDLE
- x0, x1, x2, x3  in  DATA_W each  signed operands, sampled on accepted start
- busy  out  1  high from the cycle after accepted start until result accepted
- rom_cs  out  1  ROM chip select
- rom_addr  out  3  ROM address {b1,b2,b3} after folding
- rom_data  in  ROM_W  ROM word; combinational from rom_addr/rom_cs
- y_valid  out  1  result valid
- y_ready  in  1  downstream accepts result
- y  out  ACC_W  signed coefficient

## Operation
- States: IDLE, ISSUE, DRAIN, [RND], OUT.
- IDLE: start=1 latches x0..x3 into shift regs, bit counter=DATA_W-1, acc cleared, -> ISSUE.
- ISSUE (DATA_W cycles, bit j = DATA_W-1 down to 0): rom_cs=1; with x0[j]=0, rom_addr={x1[j],x2[j],x3[j]}; with x0[j]=1, rom_addr=~{x1[j],x2[j],x3[j]}, fold flag set. Address, fold flag and msb flag (j==DATA_W-1) are registered and pipelined one stage.
- Accumulate one cycle after issue: t = sign-extend(rom_data); negate if fold XOR msb; acc <= (acc<<<1) + t. On the MSB slice acc is 0, so the result equals sum over j of 2^j·t_j with the MSB weight negative.
- After the last issue -> DRAIN (one cycle, final accumulate, rom_cs=0) -> OUT (or RND when configured).
- OUT: y_valid=1, y=acc held stable until y_ready=1; on handshake -> IDLE, y_valid=0 next cycle.
- start during non-IDLE states is ignored (no queuing). start in the same cycle as the OUT handshake is ignored; it is accepted next cycle.
- Arithmetic: no overflow is possible within ACC_W; the negation of the most-negative ROM word is computed at ACC_W width.

## Timing
- Reset (asynchronous, any state): state=IDLE; busy=0, rom_cs=0, rom_addr=0, y_valid=0, y=0, acc=0. A transaction in flight is discarded.
- Start accepted at edge 0. ISSUE spans cycles 1..DATA_W. DRAIN is cycle DATA_W+1. y_valid rises in cycle DATA_W+2 (18 cycles for default). +1 with rounding.
- rom_addr/rom_cs are registered outputs; rom_data is consumed in the cycle after its address is presented.
- Throughput: one result per DATA_W+3 cycles when y_ready is held high.

## Configuration
- DA_ROUND_EN defined: extra RND state (+1 cycle) computes round-half-up of acc >>> 14, saturated to DATA_W signed, sign-extended onto y.
- DA_ROUND_EN undefined: no RND state; y is the raw ACC_W accumulator (Q·14).

## Structure
- Shared package da_dct_pkg: DATA_W/ROM_W/ACC_W/ROM_FRAC(14) constants and the state enum.
- One sub-module: da_shift_acc (fold/msb negate, shift-add, optional round/saturate). FSM, operand shift registers and address generation are in the top.

## Test plan
- x0..x3=0, start -> every issued address 000, y=0, y_valid at cycle 18.
- x3=0x0001, others 0 -> only the LSB slice addresses 001 (0x2D41), y=11585.
- x0=0x0001, others 0 -> the LSB slice is folded to address 111 (-11586) and negated, y=11586.
- x3=0x8000, others 0 -> the MSB slice addresses 001 and is negated, y=-11585·2^15=-379617280.
- y_ready held low 5 cycles at OUT, plus start pulses during ISSUE -> y stable, starts ignored, one result only.
- rst_n low mid-ISSUE -> all outputs 0 immediately; a new start after release yields a correct result.
